// File: rtl/trace_collector.sv
// Pairs retiring-instruction headers with their in-order destination writeback beats
// and emits one single-cycle trace record per header to the simulation tracer sink.
module trace_collector #(
  parameter  int ARCH_LEN     = 32,
  parameter  int NUM_WARPS    = 8,
  parameter  int NUM_LANES    = 16,
  parameter  int REG_BITS     = 8,
  parameter  int HDR_DEPTH    = 4,
  localparam int WARP_ID_BITS = $clog2(NUM_WARPS)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          hdr_valid,
  output logic                          hdr_ready,
  input  logic [ARCH_LEN-1:0]           hdr_pc,
  input  logic [WARP_ID_BITS-1:0]       hdr_warpId,
  input  logic [NUM_LANES-1:0]          hdr_tmask,
  input  logic [1:0]                    hdr_nregs,
  input  logic                          wb_valid,
  output logic                          wb_ready,
  input  logic [REG_BITS-1:0]           wb_address,
  input  logic [NUM_LANES*ARCH_LEN-1:0] wb_data,
  output logic                          trace_valid,
  output logic [ARCH_LEN-1:0]           trace_pc,
  output logic [WARP_ID_BITS-1:0]       trace_warpId,
  output logic [NUM_LANES-1:0]          trace_tmask,
  output logic                          trace_regs_0_enable,
  output logic [REG_BITS-1:0]           trace_regs_0_address,
  output logic [NUM_LANES*ARCH_LEN-1:0] trace_regs_0_data,
  output logic                          trace_regs_1_enable,
  output logic [REG_BITS-1:0]           trace_regs_1_address,
  output logic [NUM_LANES*ARCH_LEN-1:0] trace_regs_1_data,
  output logic                          trace_regs_2_enable,
  output logic [REG_BITS-1:0]           trace_regs_2_address,
  output logic [NUM_LANES*ARCH_LEN-1:0] trace_regs_2_data,
  output logic [31:0]                   rec_count
);

  localparam int DATA_W = NUM_LANES * ARCH_LEN;
  localparam int PTR_W  = $clog2(HDR_DEPTH);

  typedef struct packed {
    logic [ARCH_LEN-1:0]     pc;
    logic [WARP_ID_BITS-1:0] warp;
    logic [NUM_LANES-1:0]    tmask;
    logic [1:0]              nregs;
  } hdr_t;

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_EMIT} state_t;

  hdr_t           fifo_mem_q [HDR_DEPTH];
  logic [PTR_W:0] wr_ptr_q, rd_ptr_q;
  logic           fifo_empty, fifo_full;
  logic           hdr_fire, wb_fire, do_load;
  hdr_t           head;

  state_t                  state_q;
  logic [ARCH_LEN-1:0]     pc_q;
  logic [WARP_ID_BITS-1:0] warp_q;
  logic [NUM_LANES-1:0]    tmask_q;
  logic [1:0]              nregs_q;
  logic [1:0]              cnt_q;
  logic                    slot_en_q   [3];
  logic [REG_BITS-1:0]     slot_addr_q [3];
  logic [DATA_W-1:0]       slot_data_q [3];
  logic                    trace_valid_q, wb_ready_q;
  logic [31:0]             rec_count_q;

  // Extra pointer bit distinguishes full from empty when the index bits match.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign hdr_ready  = !fifo_full && reset;
  assign hdr_fire   = hdr_valid && hdr_ready;
  assign head       = fifo_mem_q[rd_ptr_q[PTR_W-1:0]];
  assign do_load    = !fifo_empty && ((state_q == S_IDLE) || (state_q == S_EMIT));
  assign wb_fire    = wb_valid && wb_ready_q;

  // NOTE: FIFO storage has no reset; an entry is only read after it has been written.
  always_ff @(posedge clock) begin
    if (hdr_fire) fifo_mem_q[wr_ptr_q[PTR_W-1:0]] <= '{hdr_pc, hdr_warpId, hdr_tmask, hdr_nregs};
  end

  // NOTE: state is written with <= so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (hdr_fire) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_load)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      pc_q          <= '0;
      warp_q        <= '0;
      tmask_q       <= '0;
      nregs_q       <= '0;
      cnt_q         <= '0;
      trace_valid_q <= 1'b0;
      wb_ready_q    <= 1'b0;
      rec_count_q   <= '0;
      for (int k = 0; k < 3; k++) begin
        slot_en_q[k]   <= 1'b0;
        slot_addr_q[k] <= '0;
        slot_data_q[k] <= '0;
      end
    end else begin
      trace_valid_q <= 1'b0;
      wb_ready_q    <= 1'b0;
      if (state_q == S_EMIT) rec_count_q <= rec_count_q + 32'd1;
      if (do_load) begin
        pc_q    <= head.pc;
        warp_q  <= head.warp;
        tmask_q <= head.tmask;
        nregs_q <= head.nregs;
        cnt_q   <= '0;
        for (int k = 0; k < 3; k++) begin
          slot_en_q[k]   <= 1'b0;
          slot_addr_q[k] <= '0;
          slot_data_q[k] <= '0;
        end
        if (head.nregs == 2'd0) begin
          state_q       <= S_EMIT;
          trace_valid_q <= 1'b1;
        end else begin
          state_q    <= S_COLLECT;
          wb_ready_q <= 1'b1;
        end
      end else begin
        case (state_q)
          S_COLLECT: begin
            wb_ready_q <= 1'b1;
            if (wb_fire) begin
              for (int k = 0; k < 3; k++) begin
                if (cnt_q == 2'(k)) begin
                  slot_en_q[k]   <= 1'b1;
                  slot_addr_q[k] <= wb_address;
                  slot_data_q[k] <= wb_data;
                end
              end
              cnt_q <= cnt_q + 2'd1;
              if (cnt_q + 2'd1 == nregs_q) begin
                state_q       <= S_EMIT;
                trace_valid_q <= 1'b1;
                wb_ready_q    <= 1'b0;
              end
            end
          end
          S_EMIT:  state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign wb_ready             = wb_ready_q;
  assign trace_valid          = trace_valid_q;
  assign trace_pc             = pc_q;
  assign trace_warpId         = warp_q;
  assign trace_tmask          = tmask_q;
  assign trace_regs_0_enable  = slot_en_q[0];
  assign trace_regs_0_address = slot_addr_q[0];
  assign trace_regs_0_data    = slot_data_q[0];
  assign trace_regs_1_enable  = slot_en_q[1];
  assign trace_regs_1_address = slot_addr_q[1];
  assign trace_regs_1_data    = slot_data_q[1];
  assign trace_regs_2_enable  = slot_en_q[2];
  assign trace_regs_2_address = slot_addr_q[2];
  assign trace_regs_2_data    = slot_data_q[2];
  assign rec_count            = rec_count_q;

endmodule

// File: tb/tb_trace_collector.sv
// Directed and randomized bench for trace_collector: records are predicted by pairing
// accepted headers with accepted writeback beats in order, plus directed timing checks.
module tb_trace_collector;

  localparam int DW = 512;

  logic            clock = 1'b0;
  logic            reset;
  logic            hdr_valid, hdr_ready;
  logic [31:0]     hdr_pc;
  logic [2:0]      hdr_warpId;
  logic [15:0]     hdr_tmask;
  logic [1:0]      hdr_nregs;
  logic            wb_valid, wb_ready;
  logic [7:0]      wb_address;
  logic [DW-1:0]   wb_data;
  logic            trace_valid;
  logic [31:0]     trace_pc;
  logic [2:0]      trace_warpId;
  logic [15:0]     trace_tmask;
  logic            trace_regs_0_enable, trace_regs_1_enable, trace_regs_2_enable;
  logic [7:0]      trace_regs_0_address, trace_regs_1_address, trace_regs_2_address;
  logic [DW-1:0]   trace_regs_0_data, trace_regs_1_data, trace_regs_2_data;
  logic [31:0]     rec_count;

  trace_collector dut (
    .clock(clock), .reset(reset),
    .hdr_valid(hdr_valid), .hdr_ready(hdr_ready), .hdr_pc(hdr_pc),
    .hdr_warpId(hdr_warpId), .hdr_tmask(hdr_tmask), .hdr_nregs(hdr_nregs),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_address(wb_address), .wb_data(wb_data),
    .trace_valid(trace_valid), .trace_pc(trace_pc), .trace_warpId(trace_warpId),
    .trace_tmask(trace_tmask),
    .trace_regs_0_enable(trace_regs_0_enable), .trace_regs_0_address(trace_regs_0_address),
    .trace_regs_0_data(trace_regs_0_data),
    .trace_regs_1_enable(trace_regs_1_enable), .trace_regs_1_address(trace_regs_1_address),
    .trace_regs_1_data(trace_regs_1_data),
    .trace_regs_2_enable(trace_regs_2_enable), .trace_regs_2_address(trace_regs_2_address),
    .trace_regs_2_data(trace_regs_2_data),
    .rec_count(rec_count)
  );

  always #5 clock = ~clock;

  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] pc;
    logic [2:0]  warp;
    logic [15:0] tmask;
    logic [1:0]  nregs;
  } hdr_s;

  typedef struct {
    logic [7:0]    addr;
    logic [DW-1:0] data;
  } beat_s;

  typedef struct {
    logic [31:0]             pc;
    logic [2:0]              warp;
    logic [15:0]             tmask;
    logic [2:0]              en;
    logic [2:0][7:0]         addr;
    logic [2:0][DW-1:0]      data;
  } rec_s;

  hdr_s  hdr_q  [$];
  beat_s beat_q [$];
  rec_s  rec_q  [$];
  rec_s  mon_r;
  int    errors = 0;
  int    checks = 0;
  int    total_hdr = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every presented record is captured mid-cycle, the way the sink would see it.
  always @(negedge clock) begin
    if (reset === 1'b1 && trace_valid === 1'b1) begin
      mon_r.pc    = trace_pc;
      mon_r.warp  = trace_warpId;
      mon_r.tmask = trace_tmask;
      mon_r.en    = {trace_regs_2_enable, trace_regs_1_enable, trace_regs_0_enable};
      mon_r.addr  = {trace_regs_2_address, trace_regs_1_address, trace_regs_0_address};
      mon_r.data  = {trace_regs_2_data, trace_regs_1_data, trace_regs_0_data};
      rec_q.push_back(mon_r);
    end
  end

  // Notes accepted transfers for the reference, then advances one clock.
  task automatic tick();
    hdr_s  h;
    beat_s b;
    if (hdr_valid && hdr_ready) begin
      h.pc = hdr_pc; h.warp = hdr_warpId; h.tmask = hdr_tmask; h.nregs = hdr_nregs;
      hdr_q.push_back(h);
      total_hdr++;
    end
    if (wb_valid && wb_ready) begin
      b.addr = wb_address; b.data = wb_data;
      beat_q.push_back(b);
    end
    @(posedge clock); #1;
  endtask

  // Reference: record i = header i plus the next nregs beats, unused slots all zero.
  task automatic score();
    rec_s  r;
    hdr_s  h;
    beat_s b;
    logic [2:0]         en;
    logic [2:0][7:0]    addr;
    logic [2:0][DW-1:0] data;
    while (rec_q.size() > 0) begin
      r = rec_q.pop_front();
      check("rec_has_header", DW'(hdr_q.size() > 0), DW'(1));
      if (hdr_q.size() == 0) continue;
      h = hdr_q.pop_front();
      check("rec_has_beats", DW'(beat_q.size() >= int'(h.nregs)), DW'(1));
      en = '0; addr = '0; data = '0;
      for (int k = 0; k < int'(h.nregs); k++) begin
        if (beat_q.size() > 0) begin
          b = beat_q.pop_front();
          en[k] = 1'b1; addr[k] = b.addr; data[k] = b.data;
        end
      end
      check("rec_pc", DW'(r.pc), DW'(h.pc));
      check("rec_warp", DW'(r.warp), DW'(h.warp));
      check("rec_tmask", DW'(r.tmask), DW'(h.tmask));
      check("rec_enables", DW'(r.en), DW'(en));
      for (int k = 0; k < 3; k++) begin
        check("rec_addr", DW'(r.addr[k]), DW'(addr[k]));
        check("rec_data", r.data[k], data[k]);
      end
    end
  endtask

  task automatic do_reset(input int cycles);
    score();
    hdr_valid = 1'b0; wb_valid = 1'b0;
    reset = 1'b0;
    hdr_q.delete(); beat_q.delete();
    total_hdr = 0;
    repeat (cycles) begin @(posedge clock); #1; end
    reset = 1'b1;
    #1;
  endtask

  task automatic set_hdr(input logic [31:0] pc, input logic [2:0] w, input logic [15:0] tm,
                         input logic [1:0] n);
    hdr_valid = 1'b1; hdr_pc = pc; hdr_warpId = w; hdr_tmask = tm; hdr_nregs = n;
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int g = 0; g < 16; g++) d[32*g +: 32] = $urandom;
    return d;
  endfunction

  int unsigned   t;
  int            accepted, seen;
  logic          fired;
  logic [DW-1:0] lanes_g, held;

  initial begin
    hdr_valid = 0; hdr_pc = 0; hdr_warpId = 0; hdr_tmask = 0; hdr_nregs = 0;
    wb_valid = 0; wb_address = 0; wb_data = 0;
    reset = 1'b1;
    #1 reset = 1'b0;

    // Reset hold and release
    repeat (3) tick();
    check("rst_trace_valid", DW'(trace_valid), DW'(0));
    check("rst_hdr_ready", DW'(hdr_ready), DW'(0));
    check("rst_wb_ready", DW'(wb_ready), DW'(0));
    check("rst_rec_count", DW'(rec_count), DW'(0));
    check("rst_hdr_fields", DW'({trace_pc, trace_warpId, trace_tmask}), DW'(0));
    check("rst_slots_ctl", DW'({trace_regs_0_enable, trace_regs_1_enable, trace_regs_2_enable,
          trace_regs_0_address, trace_regs_1_address, trace_regs_2_address}), DW'(0));
    check("rst_slots_data", trace_regs_0_data | trace_regs_1_data | trace_regs_2_data, DW'(0));
    reset = 1'b1;
    tick();
    check("rel_hdr_ready", DW'(hdr_ready), DW'(1));
    check("rel_wb_ready", DW'(wb_ready), DW'(0));

    // nregs=2 record with back-to-back beats
    for (int g = 0; g < 16; g++) lanes_g[32*g +: 32] = 32'(g);
    t = cyc;
    set_hdr(32'h8000_0000, 3'd3, 16'hFFFF, 2'd2);
    tick();
    hdr_valid = 1'b0;
    check("t2_valid_t1", DW'(trace_valid), DW'(0));
    check("t2_wbready_t1", DW'(wb_ready), DW'(0));
    tick();
    check("t2_wbready_t2", DW'(wb_ready), DW'(1));
    wb_valid = 1'b1; wb_address = 8'd5; wb_data = lanes_g;
    tick();
    check("t2_valid_t3", DW'(trace_valid), DW'(0));
    wb_address = 8'd7; wb_data = {16{32'hA5A5_A5A5}};
    tick();
    wb_valid = 1'b0;
    check("t2_cycle", DW'(cyc), DW'(t + 4));
    check("t2_valid_t4", DW'(trace_valid), DW'(1));
    check("t2_pc", DW'(trace_pc), DW'(32'h8000_0000));
    check("t2_warp", DW'(trace_warpId), DW'(3));
    check("t2_tmask", DW'(trace_tmask), DW'(16'hFFFF));
    check("t2_slot0_ctl", DW'({trace_regs_0_enable, trace_regs_0_address}), DW'({1'b1, 8'd5}));
    check("t2_slot0_data", trace_regs_0_data, lanes_g);
    check("t2_slot1_ctl", DW'({trace_regs_1_enable, trace_regs_1_address}), DW'({1'b1, 8'd7}));
    check("t2_slot1_data", trace_regs_1_data, {16{32'hA5A5_A5A5}});
    check("t2_slot2", DW'({trace_regs_2_enable, trace_regs_2_address}) | trace_regs_2_data, DW'(0));
    tick();
    check("t2_valid_t5", DW'(trace_valid), DW'(0));
    check("t2_rec_count", DW'(rec_count), DW'(1));
    check("t2_pc_held", DW'(trace_pc), DW'(32'h8000_0000));
    score();

    // Four nregs=0 headers on consecutive cycles stream one record per cycle
    do_reset(2);
    for (int i = 0; i < 7; i++) begin
      if (i < 4) set_hdr(32'h100 + 32'(4 * i), 3'(i), 16'(i + 1), 2'd0);
      else hdr_valid = 1'b0;
      if (i >= 2 && i <= 5) begin
        check("t3_stream_valid", DW'(trace_valid), DW'(1));
        check("t3_stream_pc", DW'(trace_pc), DW'(32'h100 + 32'(4 * (i - 2))));
      end
      if (i == 6) check("t3_stream_end", DW'(trace_valid), DW'(0));
      tick();
    end
    check("t3_rec_count", DW'(rec_count), DW'(4));
    score();

    // FIFO fill with nregs=1 headers and no beats, then drain one beat per cycle
    do_reset(2);
    accepted = 0;
    for (int i = 0; i < 12; i++) begin
      if (!hdr_ready) break;
      set_hdr($urandom, 3'($urandom), 16'($urandom), 2'd1);
      accepted++;
      tick();
    end
    check("t4_accepted", DW'(accepted), DW'(5));
    repeat (2) begin
      tick();
      check("t4_full_hold", DW'(hdr_ready), DW'(0));
    end
    hdr_valid = 1'b0;
    wb_valid = 1'b1; wb_address = 8'($urandom); wb_data = rand_data();
    seen = 0;
    for (int i = 0; i < 30 && seen < 5; i++) begin
      if (trace_valid) begin
        if (seen == 0) check("t4_pop_no_push", DW'(hdr_ready), DW'(0));
        seen++;
      end
      fired = wb_ready;
      tick();
      if (fired) begin wb_address = 8'($urandom); wb_data = rand_data(); end
    end
    wb_valid = 1'b0;
    check("t4_emitted", DW'(seen), DW'(5));
    check("t4_rec_count", DW'(rec_count), DW'(5));
    score();

    // nregs=3 with idle gaps between beats; a 4th beat stalls until a new record collects
    do_reset(2);
    set_hdr(32'hCAFE_0000, 3'd6, 16'h0F0F, 2'd3);
    tick();
    hdr_valid = 1'b0;
    tick();
    for (int b = 0; b < 3; b++) begin
      wb_valid = 1'b1; wb_address = 8'(10 + b); wb_data = rand_data();
      check("t5_ready_beat", DW'(wb_ready), DW'(1));
      tick();
      wb_valid = 1'b0;
      if (b < 2) begin
        repeat (2) begin
          check("t5_ready_gap", DW'(wb_ready), DW'(1));
          check("t5_no_valid_gap", DW'(trace_valid), DW'(0));
          tick();
        end
      end
    end
    check("t5_emit_after_3rd", DW'(trace_valid), DW'(1));
    held = rand_data();
    wb_valid = 1'b1; wb_address = 8'd42; wb_data = held;
    check("t5_ready_emit", DW'(wb_ready), DW'(0));
    tick();
    check("t5_idle_valid", DW'(trace_valid), DW'(0));
    check("t5_idle_ready", DW'(wb_ready), DW'(0));
    set_hdr(32'hCAFE_0004, 3'd1, 16'h0001, 2'd1);
    tick();
    hdr_valid = 1'b0;
    tick();
    check("t5_collect_ready", DW'(wb_ready), DW'(1));
    tick();
    wb_valid = 1'b0;
    check("t5_4th_valid", DW'(trace_valid), DW'(1));
    check("t5_4th_data", trace_regs_0_data, held);
    tick();
    score();

    // Reset mid-record abandons the record and the queued header
    do_reset(2);
    set_hdr(32'h0000_2000, 3'd2, 16'h00FF, 2'd2);
    tick();
    set_hdr(32'h0000_2004, 3'd2, 16'h00FF, 2'd2);
    tick();
    hdr_valid = 1'b0;
    wb_valid = 1'b1; wb_address = 8'd9; wb_data = rand_data();
    tick();
    wb_valid = 1'b0;
    score();
    reset = 1'b0;
    hdr_q.delete(); beat_q.delete(); total_hdr = 0;
    #1;
    check("t6_rst_valid", DW'(trace_valid), DW'(0));
    check("t6_rst_count", DW'(rec_count), DW'(0));
    check("t6_rst_slot0", DW'(trace_regs_0_enable), DW'(0));
    check("t6_rst_ready", DW'({hdr_ready, wb_ready}), DW'(0));
    repeat (2) tick();
    reset = 1'b1;
    tick();
    check("t6_no_record", DW'(rec_q.size()), DW'(0));
    check("t6_count_after", DW'(rec_count), DW'(0));
    t = cyc;
    set_hdr(32'h0000_3000, 3'd5, 16'hAAAA, 2'd0);
    tick();
    hdr_valid = 1'b0;
    check("t6_valid_t1", DW'(trace_valid), DW'(0));
    tick();
    check("t6_cycle", DW'(cyc), DW'(t + 2));
    check("t6_valid_t2", DW'(trace_valid), DW'(1));
    check("t6_pc", DW'(trace_pc), DW'(32'h0000_3000));
    tick();
    check("t6_rec_count", DW'(rec_count), DW'(1));
    score();

    // Randomized traffic against the reference
    do_reset(2);
    for (int i = 0; i < 400; i++) begin
      if (!hdr_valid && $urandom_range(0, 2) == 0)
        set_hdr($urandom, 3'($urandom), 16'($urandom), 2'($urandom_range(0, 3)));
      if (!wb_valid && $urandom_range(0, 2) != 0) begin
        wb_valid = 1'b1; wb_address = 8'($urandom); wb_data = rand_data();
      end
      fired = wb_valid && wb_ready;
      accepted = int'(hdr_valid && hdr_ready);
      tick();
      if (fired) wb_valid = 1'b0;
      if (accepted != 0) hdr_valid = 1'b0;
      score();
    end
    hdr_valid = 1'b0;
    for (int i = 0; i < 200; i++) begin
      score();
      if (hdr_q.size() == 0) break;
      if (!wb_valid) begin wb_valid = 1'b1; wb_address = 8'($urandom); wb_data = rand_data(); end
      fired = wb_ready;
      tick();
      if (fired) wb_valid = 1'b0;
    end
    wb_valid = 1'b0;
    tick();
    score();
    check("t7_drained", DW'(hdr_q.size()), DW'(0));
    check("t7_beats_used", DW'(beat_q.size()), DW'(0));
    check("t7_rec_count", DW'(rec_count), DW'(total_hdr));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
